fp_exp_aligner: RTL and testbench

Multi-cycle exponent-alignment stage for the FP add/sub datapath. It is the counterpart of the saturating exponent adder: it takes two operands' signed exponents and mantissas, computes a saturating exponent difference, and right-shifts the smaller operand's mantissa one bit per cycle, collecting guard, round and sticky bits. It sits between operand unpack and the mantissa adder, with valid/ready handshakes on both sides.

---
 rtl/fp_exp_aligner.sv | 77 +++++++
 tb/tb_fp_exp_aligner.sv | 111 +++++++++++
 2 files changed

// File: rtl/fp_exp_aligner.sv
// fp_exp_aligner: saturating exponent difference plus serial right-shift alignment of the smaller mantissa with guard/round/sticky.
module fp_exp_aligner #(
  parameter int MANT_W = 24,
  parameter int EXP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [EXP_W-1:0]  exp_diff,
  output logic              swapped,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              guard,
  output logic              round,
  output logic              sticky
);
  localparam int SR_W = MANT_W + 2;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [EXP_W:0] SR_CAP = (EXP_W + 1)'(SR_W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [EXP_W:0] d, d_abs;
  logic [EXP_W-1:0] d_sat;
  logic [CNT_W-1:0] cnt, cnt_ld;
  logic [SR_W-1:0] sr;
  logic d_neg;
  always_comb begin
    d = {exp_a[EXP_W-1], exp_a} - {exp_b[EXP_W-1], exp_b};
    d_neg = d[EXP_W];
    d_abs = d_neg ? -d : d;
    d_sat = (d[EXP_W] == d[EXP_W-1]) ? d[EXP_W-1:0] : {d[EXP_W], {(EXP_W-1){~d[EXP_W]}}};
    cnt_ld = (d_abs >= SR_CAP) ? CNT_W'(SR_W) : CNT_W'(d_abs);
    state_nx = state == IDLE  ? (in_valid ? (cnt_ld == '0 ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == CNT_W'(1) ? DONE : SHIFT) :
                                (out_ready ? IDLE : DONE);
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign mant_small = sr[SR_W-1:2];
  assign guard = sr[1];
  assign round = sr[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      sticky <= 1'b0;
      exp_out <= '0;
      exp_diff <= '0;
      swapped <= 1'b0;
      mant_big <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        cnt <= cnt_ld;
        sr <= {d_neg ? mant_a : mant_b, 2'b00};
        sticky <= 1'b0;
        exp_out <= d_neg ? exp_b : exp_a;
        exp_diff <= d_sat;
        swapped <= d_neg;
        mant_big <= d_neg ? mant_b : mant_a;
      end else if (state == SHIFT) begin
        sr <= sr >> 1;
        sticky <= sticky | sr[0];
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fp_exp_aligner.sv
// tb_fp_exp_aligner: directed scenarios for the exponent aligner with hand-computed results.
module tb_fp_exp_aligner;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, swapped, guard, round, sticky;
  logic [7:0] exp_a = 0, exp_b = 0, exp_out, exp_diff;
  logic [23:0] mant_a = 0, mant_b = 0, mant_big, mant_small;
  logic [67:0] res;
  int checks = 0, errors = 0;
  fp_exp_aligner dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
    .exp_diff(exp_diff), .swapped(swapped), .mant_big(mant_big),
    .mant_small(mant_small), .guard(guard), .round(round), .sticky(sticky)
  );
  always #5 clk = ~clk;
  assign res = {exp_out, exp_diff, swapped, mant_big, mant_small, guard, round, sticky};
  task automatic run(input logic [7:0] ea, eb, input logic [23:0] ma, mb, output int lat);
    @(negedge clk);
    exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
  endtask
  task automatic drain;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL reset_flags got %b want 10", {in_ready, out_valid}); end
    checks++; if (res !== 68'h0) begin errors++; $display("FAIL reset_data got %h want 0", res); end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_equal;
    int lat;
    run(8'd5, 8'd5, 24'h800000, 24'hC00000, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL equal_latency got %0d want 1", lat); end
    checks++; if (res !== {8'd5, 8'd0, 1'b0, 24'h800000, 24'hC00000, 3'b000}) begin errors++; $display("FAIL equal_result got %h", res); end
    drain();
  endtask
  task automatic test_b_larger(input string tag);
    int lat;
    run(8'd3, 8'd7, 24'hFFFFFF, 24'h800000, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL %s_latency got %0d want 5", tag, lat); end
    checks++; if (res !== {8'd7, 8'hFC, 1'b1, 24'h800000, 24'h0FFFFF, 3'b111}) begin errors++; $display("FAIL %s_result got %h", tag, res); end
    drain();
  endtask
  task automatic test_saturation;
    int lat;
    run(8'h7F, 8'h80, 24'hABCDEF, 24'h800001, lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL sat_latency got %0d want 27", lat); end
    checks++; if (res !== {8'h7F, 8'h7F, 1'b0, 24'hABCDEF, 24'h000000, 3'b001}) begin errors++; $display("FAIL sat_result got %h", res); end
    drain();
    run(8'h80, 8'h7F, 24'h800001, 24'hABCDEF, lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL satrev_latency got %0d want 27", lat); end
    checks++; if (res !== {8'h7F, 8'h80, 1'b1, 24'hABCDEF, 24'h000000, 3'b001}) begin errors++; $display("FAIL satrev_result got %h", res); end
    drain();
  endtask
  task automatic test_negative;
    int lat;
    run(8'hFF, 8'hFE, 24'h900000, 24'h000003, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL neg_latency got %0d want 2", lat); end
    checks++; if (res !== {8'hFF, 8'h01, 1'b0, 24'h900000, 24'h000001, 3'b100}) begin errors++; $display("FAIL neg_result got %h", res); end
    drain();
  endtask
  task automatic test_backpressure;
    int lat;
    logic [67:0] want;
    want = {8'd2, 8'd2, 1'b0, 24'hC00000, 24'h000001, 3'b010};
    run(8'd2, 8'd0, 24'hC00000, 24'h000005, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin exp_a = 8'd0; exp_b = 8'd0; mant_a = 24'h111111; mant_b = 24'h222222; in_valid = 1; end
      else in_valid = 0;
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, res} !== {2'b10, want}) begin errors++; $display("FAIL bp_hold cycle %0d got %b %h want 10 %h", i, {out_valid, in_ready}, res, want); end
    end
    in_valid = 0;
    drain();
    checks++; if ({out_valid, in_ready, res} !== {2'b01, want}) begin errors++; $display("FAIL bp_release got %b %h want 01 %h", {out_valid, in_ready}, res, want); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_no_accept got %b want 01", {out_valid, in_ready}); end
  endtask
  task automatic test_reset_mid_shift;
    @(negedge clk);
    exp_a = 8'd0; exp_b = 8'd20; mant_a = 24'hFFFFFF; mant_b = 24'h800000; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (7) @(posedge clk);
    #4 rst_n = 0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_flags got %b want 01", {out_valid, in_ready}); end
    checks++; if (res !== 68'h0) begin errors++; $display("FAIL rst_mid_data got %h want 0", res); end
    @(negedge clk); rst_n = 1;
    test_b_larger("post_reset");
  endtask
  initial begin
    test_reset();
    test_equal();
    test_b_larger("b_larger");
    test_saturation();
    test_negative();
    test_backpressure();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
